// File: rtl/seg7_scroll_mux.sv
// Multiplexed N-digit 7-segment driver with a scrolling message buffer.
// Digits refresh one at a time; the window offset steps through the message with wrap.
module seg7_scroll_mux #(
  parameter int N_DIGITS    = 4,
  parameter int MSG_MAX     = 32,
  parameter int REFRESH_DIV = 50000,
  parameter int SCROLL_DIV  = 25000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic [4:0]          load_code,
  input  logic                clear,
  input  logic                start,
  input  logic                stop,
  input  logic                scroll_en,
  output logic                busy,
  output logic [N_DIGITS-1:0] an,
  output logic [6:0]          seg
);

  localparam int LW = $clog2(MSG_MAX + 1);
  localparam int AW = (MSG_MAX > 1) ? $clog2(MSG_MAX) : 1;
  localparam int DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int SW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] len_q;
  logic [LW-1:0] ofs_q;
  logic [DW-1:0] dig_q;
  logic [RW-1:0] ref_q;
  logic [SW-1:0] scr_q;
  logic [4:0]    msg [MSG_MAX];
  logic [LW:0]   idx;
  logic [4:0]    code;
  logic          accept;
  logic          go;
  logic          ref_tc;
  logic          scr_tc;
  logic          dig_last;
  logic          ofs_last;
  logic          unused_idx_hi;

  function automatic logic [6:0] decode(input logic [4:0] c);
    logic [6:0] s;
    s = 7'h00;
    case (c)
      5'd0:  s = 7'h2A;
      5'd1:  s = 7'h15;
      5'd2:  s = 7'h67;
      5'd3:  s = 7'h37;
      5'd4:  s = 7'h6D;
      5'd5:  s = 7'h37;
      5'd6:  s = 7'h3C;
      5'd7:  s = 7'h6D;
      5'd8:  s = 7'h5B;
      5'd9:  s = 7'h05;
      5'd10: s = 7'h0E;
      5'd11: s = 7'h77;
      5'd12: s = 7'h06;
      5'd13: s = 7'h73;
      5'd14: s = 7'h5F;
      5'd15: s = 7'h7E;
      5'd16: s = 7'h4F;
      5'd17: s = 7'h06;
      5'd18: s = 7'h37;
      5'd19: s = 7'h0F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  always_comb begin
    state_d    = state_q;
    load_ready = 1'b0;
    busy       = 1'b0;
    accept     = 1'b0;
    go         = 1'b0;
    unique case (state_q)
      IDLE: begin
        load_ready = (len_q < LW'(MSG_MAX));
        accept     = load_valid && load_ready && !clear;
        go         = start && !clear && (len_q != '0);
        if (go) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (stop) state_d = IDLE;
      end
    endcase
  end

  assign ref_tc   = (ref_q == RW'(REFRESH_DIV - 1));
  assign scr_tc   = (scr_q == SW'(SCROLL_DIV - 1));
  assign dig_last = (dig_q == DW'(N_DIGITS - 1));
  assign ofs_last = (ofs_q == len_q - LW'(1));

  // (ofs+digit) mod len; short messages may need several subtractions
  always_comb begin
    idx = {1'b0, ofs_q} + (LW + 1)'(dig_q);
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx >= {1'b0, len_q}) idx = idx - {1'b0, len_q};
    end
  end

  assign code          = msg[idx[AW-1:0]];
  assign unused_idx_hi = ^idx[LW:AW];

  always_ff @(posedge clk) begin
    if (accept) msg[len_q[AW-1:0]] <= load_code;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      ofs_q   <= '0;
      dig_q   <= '0;
      ref_q   <= '0;
      scr_q   <= '0;
      an      <= '0;
      seg     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) begin
        if (clear) len_q <= '0;
        else if (accept) len_q <= len_q + LW'(1);
        if (go) begin
          ofs_q <= '0;
          dig_q <= '0;
          ref_q <= '0;
          scr_q <= '0;
        end
      end else begin
        if (ref_tc) begin
          ref_q <= '0;
          dig_q <= dig_last ? '0 : dig_q + DW'(1);
        end else begin
          ref_q <= ref_q + RW'(1);
        end
        if (scroll_en) begin
          if (scr_tc) begin
            scr_q <= '0;
            ofs_q <= ofs_last ? '0 : ofs_q + LW'(1);
          end else begin
            scr_q <= scr_q + SW'(1);
          end
        end
      end
      if (state_q == RUN && !stop) begin
        an  <= N_DIGITS'(1) << dig_q;
        seg <= decode(code);
      end else begin
        an  <= '0;
        seg <= '0;
      end
    end
  end

endmodule
